// File: rtl/nco_sweep_ctrl.sv
// Linear frequency-sweep sequencer for the phase-accumulator NCO.
// Steps the tuning word from f_start toward f_stop by f_step. Each point is held
// for max(dwell,1) cycles. The last point is clamped to f_stop, so the word never
// wraps past the top of the range. Single-shot or repeat mode, with abort and hold.
// Ports:
//   sys_clk, sys_rst_n      : clock, synchronous active-low reset
//   start, abort, hold      : sweep control
//   repeat_en               : restart at f_start after each completed sweep
//   f_start/f_stop/f_step   : sweep range and increment (latched on accepted start)
//   dwell                   : cycles per point (latched on accepted start)
//   fword, fword_vld        : tuning word to the NCO, 1-cycle pulse on each change
//   busy, done              : sweep active, 1-cycle completion pulse
module nco_sweep_ctrl #(
  parameter int unsigned FW_W = 32,
  parameter int unsigned DW_W = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  input  logic            repeat_en,
  input  logic [FW_W-1:0] f_start,
  input  logic [FW_W-1:0] f_stop,
  input  logic [FW_W-1:0] f_step,
  input  logic [DW_W-1:0] dwell,
  output logic [FW_W-1:0] fword,
  output logic            fword_vld,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Sweep configuration captured when a start is accepted.
  typedef struct packed {
    logic [FW_W-1:0] f_start;
    logic [FW_W-1:0] f_stop;
    logic [FW_W-1:0] f_step;
    logic [DW_W-1:0] dwell;
    logic            single;  // degenerate config: output f_start only
  } cfg_t;

  state_t          state, state_n;
  cfg_t            cfg, cfg_n;
  logic [DW_W-1:0] cnt, cnt_n;
  logic [FW_W-1:0] fword_n;
  logic            fword_vld_n, busy_n, done_n;

  logic [DW_W-1:0] dwell_eff;
  logic [FW_W:0]   nxt;

  assign dwell_eff = (cfg.dwell == '0) ? DW_W'(1) : cfg.dwell;
  // The extra top bit keeps the sum from wrapping before it is compared against f_stop.
  assign nxt       = {1'b0, fword} + {1'b0, cfg.f_step};

  // State and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      cfg       <= '0;
      cnt       <= '0;
      fword     <= '0;
      fword_vld <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cfg       <= cfg_n;
      cnt       <= cnt_n;
      fword     <= fword_n;
      fword_vld <= fword_vld_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    cfg_n       = cfg;
    cnt_n       = cnt;
    fword_n     = fword;
    fword_vld_n = 1'b0;
    busy_n      = busy;
    done_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          cfg_n.f_start = f_start;
          cfg_n.f_stop  = f_stop;
          cfg_n.f_step  = f_step;
          cfg_n.dwell   = dwell;
          cfg_n.single  = (f_step == '0) || (f_stop < f_start);
          fword_n       = f_start;
          fword_vld_n   = 1'b1;
          busy_n        = 1'b1;
          cnt_n         = DW_W'(1);
          state_n       = DWELL;
        end
      end

      DWELL, DONE: begin
        if (abort) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (state == DONE && !busy) begin
          state_n = IDLE;
        end else if (state == DWELL && hold) begin
          cnt_n = cnt;
        end else if (cnt == dwell_eff) begin
          // In repeat mode the DONE cycle is already the first cycle of the f_start point.
          if (fword == cfg.f_stop || cfg.single) begin
            done_n  = 1'b1;
            state_n = DONE;
            if (repeat_en) begin
              fword_n     = cfg.f_start;
              fword_vld_n = 1'b1;
              cnt_n       = DW_W'(1);
            end else begin
              busy_n = 1'b0;
            end
          end else if (nxt >= {1'b0, cfg.f_stop}) begin
            fword_n     = cfg.f_stop;
            fword_vld_n = 1'b1;
            cnt_n       = DW_W'(1);
            state_n     = DWELL;
          end else begin
            fword_n     = nxt[FW_W-1:0];
            fword_vld_n = 1'b1;
            cnt_n       = DW_W'(1);
            state_n     = DWELL;
          end
        end else begin
          cnt_n   = cnt + DW_W'(1);
          state_n = DWELL;
        end
      end

      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Cycle-by-cycle directed bench for nco_sweep_ctrl: each vector drives the inputs
// for one clock edge and lists the outputs expected just after that edge.
module tb_nco_sweep_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n, start, abort, hold, repeat_en;
  logic [31:0] f_start, f_stop, f_step;
  logic [15:0] dwell;
  logic [31:0] fword;
  logic        fword_vld, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int vec_idx = 0;

  nco_sweep_ctrl #(.FW_W(32), .DW_W(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .abort     (abort),
    .hold      (hold),
    .repeat_en (repeat_en),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .fword     (fword),
    .fword_vld (fword_vld),
    .busy      (busy),
    .done      (done)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    logic        rst_n, st, ab, ho, rep;
    logic [31:0] fs, fp, fe;
    logic [15:0] dw;
    logic [31:0] e_fw;
    logic        e_vld, e_busy, e_done;
  } vec_t;

  vec_t tbl[$];

  // Argument order: rst_n, start, abort, hold, repeat_en, f_start, f_step, f_stop, dwell,
  // then expected fword, fword_vld, busy, done.
  function automatic vec_t mk(logic r, logic s, logic a, logic h, logic p,
                              logic [31:0] fs, logic [31:0] fp, logic [31:0] fe,
                              logic [15:0] dw, logic [31:0] efw,
                              logic ev, logic eb, logic ed);
    vec_t v;
    v.rst_n = r;  v.st = s;  v.ab = a;  v.ho = h;  v.rep = p;
    v.fs = fs;  v.fp = fp;  v.fe = fe;  v.dw = dw;
    v.e_fw = efw;  v.e_vld = ev;  v.e_busy = eb;  v.e_done = ed;
    return v;
  endfunction

  // Idle cycle with the config inputs scrambled, so that any use of unlatched inputs shows up.
  function automatic vec_t idl(logic h, logic p, logic [31:0] efw,
                               logic ev, logic eb, logic ed);
    return mk(1, 0, 0, h, p, 32'hDEAD_0000, 32'h0000_0BAD, 32'h0000_1234, 16'd7,
              efw, ev, eb, ed);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, vec_idx, act, exp);
    end
  endtask

  // Drive at the falling edge, then check just after the next rising edge.
  task automatic apply(input vec_t v);
    sys_rst_n = v.rst_n;  start = v.st;  abort = v.ab;  hold = v.ho;
    repeat_en = v.rep;    f_start = v.fs;  f_step = v.fp;  f_stop = v.fe;
    dwell     = v.dw;
    @(posedge sys_clk);
    #1;
    check("fword",     fword,             v.e_fw);
    check("fword_vld", 32'(fword_vld),    32'(v.e_vld));
    check("busy",      32'(busy),         32'(v.e_busy));
    check("done",      32'(done),         32'(v.e_done));
    vec_idx++;
    @(negedge sys_clk);
  endtask

  initial begin
    sys_rst_n = 1'b0;  start = 1'b0;  abort = 1'b0;  hold = 1'b0;  repeat_en = 1'b0;
    f_start = '0;  f_stop = '0;  f_step = '0;  dwell = '0;

    // Reset, then the basic sweep 100 +50 -> 260 with dwell 3.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idl(0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 100, 50, 260, 3, 100, 1, 1, 0));
    tbl.push_back(idl(0, 0, 100, 0, 1, 0));
    tbl.push_back(idl(0, 0, 100, 0, 1, 0));
    tbl.push_back(idl(0, 0, 150, 1, 1, 0));
    tbl.push_back(idl(0, 0, 150, 0, 1, 0));
    tbl.push_back(idl(0, 0, 150, 0, 1, 0));
    tbl.push_back(idl(0, 0, 200, 1, 1, 0));
    tbl.push_back(idl(0, 0, 200, 0, 1, 0));
    tbl.push_back(idl(0, 0, 200, 0, 1, 0));
    tbl.push_back(idl(0, 0, 250, 1, 1, 0));
    tbl.push_back(idl(0, 0, 250, 0, 1, 0));
    tbl.push_back(idl(0, 0, 250, 0, 1, 0));
    tbl.push_back(idl(0, 0, 260, 1, 1, 0));
    tbl.push_back(idl(0, 0, 260, 0, 1, 0));
    tbl.push_back(idl(0, 0, 260, 0, 1, 0));
    tbl.push_back(idl(0, 0, 260, 0, 0, 1));
    tbl.push_back(idl(0, 0, 260, 0, 0, 0));
    // A start that arrives together with abort in IDLE is ignored.
    tbl.push_back(mk(1, 1, 1, 0, 0, 5, 1, 9, 1, 260, 0, 0, 0));
    // Overflow-safe clamp near the top of the word range.
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'hFFFF_FFE0, 32'h20, 32'hFFFF_FFF0, 1,
                     32'hFFFF_FFE0, 1, 1, 0));
    tbl.push_back(idl(0, 0, 32'hFFFF_FFF0, 1, 1, 0));
    tbl.push_back(idl(0, 0, 32'hFFFF_FFF0, 0, 0, 1));
    tbl.push_back(idl(0, 0, 32'hFFFF_FFF0, 0, 0, 0));

    @(negedge sys_clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Repeat mode 10 +10 -> 30 with dwell 2; hold stretches the second 20 point.
    apply(mk(1, 1, 0, 0, 1, 10, 10, 30, 2, 10, 1, 1, 0));
    apply(idl(0, 1, 10, 0, 1, 0));
    apply(idl(0, 1, 20, 1, 1, 0));
    apply(idl(0, 1, 20, 0, 1, 0));
    apply(idl(0, 1, 30, 1, 1, 0));
    apply(idl(0, 1, 30, 0, 1, 0));
    apply(idl(0, 1, 10, 1, 1, 1));
    apply(idl(0, 1, 10, 0, 1, 0));
    apply(idl(0, 1, 20, 1, 1, 0));
    for (int i = 0; i < 5; i++) apply(idl(1, 1, 20, 0, 1, 0));
    apply(idl(0, 1, 20, 0, 1, 0));
    apply(idl(0, 1, 30, 1, 1, 0));
    apply(idl(0, 1, 30, 0, 1, 0));
    apply(idl(0, 1, 10, 1, 1, 1));
    apply(idl(0, 0, 10, 0, 1, 0));
    apply(idl(0, 0, 20, 1, 1, 0));
    apply(idl(0, 0, 20, 0, 1, 0));
    apply(idl(0, 0, 30, 1, 1, 0));
    apply(idl(0, 0, 30, 0, 1, 0));
    apply(idl(0, 0, 30, 0, 0, 1));
    apply(idl(0, 0, 30, 0, 0, 0));

    // Abort in the middle of the 150 point, then an immediate restart.
    apply(mk(1, 1, 0, 0, 0, 100, 50, 260, 3, 100, 1, 1, 0));
    apply(idl(0, 0, 100, 0, 1, 0));
    apply(idl(0, 0, 100, 0, 1, 0));
    apply(idl(0, 0, 150, 1, 1, 0));
    apply(idl(0, 0, 150, 0, 1, 0));
    apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 150, 0, 0, 0));
    apply(mk(1, 1, 0, 0, 0, 7, 1, 8, 1, 7, 1, 1, 0));
    apply(idl(0, 0, 8, 1, 1, 0));
    apply(idl(0, 0, 8, 0, 0, 1));
    apply(idl(0, 0, 8, 0, 0, 0));

    // f_stop below f_start with dwell 0; a start while busy is ignored.
    apply(mk(1, 1, 0, 0, 0, 100, 5, 50, 0, 100, 1, 1, 0));
    apply(mk(1, 1, 0, 0, 0, 999, 1, 2000, 4, 100, 0, 0, 1));
    apply(idl(0, 0, 100, 0, 0, 0));
    // f_step of zero is also a single-point sweep.
    apply(mk(1, 1, 0, 0, 0, 40, 0, 100, 2, 40, 1, 1, 0));
    apply(idl(0, 0, 40, 0, 1, 0));
    apply(idl(0, 0, 40, 0, 0, 1));
    apply(idl(0, 0, 40, 0, 0, 0));

    // Reset while the sweep sits at 200.
    apply(mk(1, 1, 0, 0, 0, 100, 50, 260, 1, 100, 1, 1, 0));
    apply(idl(0, 0, 150, 1, 1, 0));
    apply(idl(0, 0, 200, 1, 1, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(idl(0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
- Frequency-word sequencer for the mixer's phase-accumulator sine NCO (50 MHz sys_clk domain).
- Drives the NCO tuning word through a programmable linear sweep: start, step, stop, with a fixed dwell per point.
- Single-shot or continuous-repeat modes. Supports abort and hold.
- Output `fword` connects directly to the NCO accumulator increment input; `fword_vld` tells downstream logic the tuning word has changed.

Parameters:
- FW_W, 32, tuning-word width (matches the NCO phase accumulator).
- DW_W, 16, dwell-counter width.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  reset, synchronous, active-low.
- start  input  1  1-cycle request to begin a sweep; ignored while busy=1.
- abort  input  1  terminate sweep immediately; level or pulse.
- hold  input  1  freeze dwell counter while high; fword unchanged.
- repeat_en  input  1  1 = restart at f_start after each completed sweep.
- f_start  input  FW_W  first tuning word; latched on accepted start.
- f_stop  input  FW_W  last tuning word, unsigned; latched on accepted start.
- f_step  input  FW_W  increment per point, unsigned; latched on accepted start.
- dwell  input  DW_W  cycles each point is held; 0 is treated as 1; latched on accepted start.
- fword  output  FW_W  current tuning word to the NCO.
- fword_vld  output  1  1-cycle pulse in the first cycle a new fword value is presented.
- busy  output  1  high while a sweep is active.
- done  output  1  1-cycle pulse when a sweep completes.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - fword=0, fword_vld=0, busy=0, done=0.
  - State IDLE; all latched config cleared.
  - Reset is honoured mid-sweep with no done pulse.
- States: IDLE, DWELL, DONE.
- IDLE:
  - start=1 at edge T latches config, loads fword<=f_start, sets busy=1, and moves to DWELL.
  - At T+1: fword_vld=1, dwell counter cnt=1.
- DWELL:
  - cnt increments each cycle with hold=0 and freezes with hold=1.
  - When cnt==dwell_eff, with dwell_eff = max(dwell,1), and hold=0:
    - Compute nxt = {1'b0,fword} + f_step as an FW_W+1-bit sum.
    - If fword==f_stop_l: go to DONE (final point finished).
    - Else if nxt >= {1'b0,f_stop_l}: fword<=f_stop_l (clamp, overflow-safe), fword_vld pulse, cnt<=1.
    - Else: fword<=nxt[FW_W-1:0], fword_vld pulse, cnt<=1.
  - Each point is therefore held exactly dwell_eff cycles when hold stays low.
- Degenerate configs: f_step==0 or f_stop_l < f_start_l → single-point sweep. Only f_start is output for dwell_eff cycles, then DONE.
- DONE (one cycle):
  - done=1.
  - If repeat_en=1 (sampled in this cycle): fword<=f_start_l, fword_vld=1 in the same cycle, busy stays 1, go to DWELL with cnt=1. There is no gap cycle.
  - If repeat_en=0: busy=0 in this cycle, fword holds f_stop_l (or f_start_l for a degenerate sweep), go to IDLE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, busy=0, no done pulse, no fword_vld pulse.
  - fword retains its current value.
  - abort has priority over the dwell/step logic and over DONE.
  - abort=1 together with start=1 in IDLE: start is ignored.
- start while busy=1 is ignored. Config inputs may change freely after acceptance without effect on the running sweep.
- hold=1 during DONE has no effect; hold only gates cnt.
- All outputs are registered; there is no combinational input-to-output path.

Test Plan:
- Basic sweep: reset, then start at T with f_start=100, f_step=50, f_stop=260, dwell=3, repeat_en=0.
  - fword=100 at T+1..T+3, 150 at T+4..T+6, 200 at T+7..T+9, 250 at T+10..T+12, 260 (clamped) at T+13..T+15.
  - fword_vld at T+1, T+4, T+7, T+10, T+13.
  - done and busy=0 at T+16.
- Overflow clamp: f_start=0xFFFFFFE0, f_step=0x20, f_stop=0xFFFFFFF0, dwell=1 → fword 0xFFFFFFE0 then 0xFFFFFFF0, with no wrap to 0; done 1 cycle after the second point.
- Repeat and hold: start with f_start=10, f_step=10, f_stop=30, dwell=2, repeat_en=1.
  - Sequence is 10,10,20,20,30,30,10,... with done coinciding with fword_vld on 10; busy stays 1.
  - Hold asserted 5 cycles during the 20 point stretches that point to 7 cycles.
- Abort: abort asserted mid-point (fword=150) → busy=0 next cycle, fword stays 150, no done; a new start is accepted in the following cycle.
- Degenerate and dwell=0: f_stop=50 < f_start=100, dwell=0 → fword=100 for 1 cycle, done next cycle; also start pulsed while busy is ignored.
- Reset mid-sweep: sys_rst_n low for 1 cycle at fword=200 → next cycle fword=0, busy=0, done=0, fword_vld=0.
